ysyx_25040129_wbu: RTL

Writeback unit and register scoreboard sitting in front of the register file.
- Accepts results from the EXU and the LSU through two independent valid/ready ports and merges them into a small FIFO.
- Drains the FIFO one entry per cycle into the register file's single write port (rd, reg_write, result).
- Keeps a per-register busy bit set by the issue stage and cleared on writeback, so the decoder can stall RAW/WAW hazards.

---
 rtl/ysyx_25040129_wbu.sv | 128 ++++++++++++
 1 files changed

// File: rtl/ysyx_25040129_wbu.sv
// Writeback unit: merges EXU/LSU results through a small FIFO into the single
// register-file write port and tracks per-register pending-write (busy) bits.
module ysyx_25040129_wbu #(
    parameter int REGS_DIG = 4,
    parameter int DEPTH    = 4,
    parameter int PTR_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_valid,
    input  logic [REGS_DIG-1:0] alloc_rd,
    output logic                alloc_ready,
    input  logic                exu_valid,
    output logic                exu_ready,
    input  logic                exu_wen,
    input  logic [REGS_DIG-1:0] exu_rd,
    input  logic [31:0]         exu_data,
    input  logic                lsu_valid,
    output logic                lsu_ready,
    input  logic                lsu_wen,
    input  logic [REGS_DIG-1:0] lsu_rd,
    input  logic [31:0]         lsu_data,
    output logic [REGS_DIG-1:0] rd,
    output logic                reg_write,
    output logic [31:0]         result,
    input  logic [REGS_DIG-1:0] src1_id,
    input  logic [REGS_DIG-1:0] src2_id,
    output logic                src1_busy,
    output logic                src2_busy,
    output logic                wb_err
);

    localparam int NREGS = 1 << REGS_DIG;
    localparam logic [PTR_W:0] CNT_LIMIT = (PTR_W+1)'(DEPTH - 2);

    logic [NREGS-1:0]    busy;
    logic [NREGS-1:0]    busy_next;
    logic [REGS_DIG-1:0] rd_mem   [DEPTH];
    logic [31:0]         data_mem [DEPTH];
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [PTR_W:0]      count;

    logic in_ready;
    logic exu_push;
    logic lsu_push;
    logic pop;
    logic alloc_fire;
    logic err_push;
    logic [PTR_W-1:0] lsu_slot;

    // Both ports share one readiness so each is always guaranteed a free slot.
    assign in_ready  = (count <= CNT_LIMIT);
    assign exu_ready = in_ready;
    assign lsu_ready = in_ready;

    assign exu_push = exu_valid & in_ready & exu_wen & (exu_rd != '0);
    assign lsu_push = lsu_valid & in_ready & lsu_wen & (lsu_rd != '0);
    assign pop      = (count != '0);
    assign lsu_slot = tail + PTR_W'(exu_push);

    assign alloc_ready = (alloc_rd == '0) | ~busy[alloc_rd];
    assign alloc_fire  = alloc_valid & alloc_ready & (alloc_rd != '0);
    assign src1_busy   = busy[src1_id];
    assign src2_busy   = busy[src2_id];

    assign err_push = (exu_push & ~busy[exu_rd]) | (lsu_push & ~busy[lsu_rd]);

    // Clear on the edge that completes the write, set on allocation; x0 never busy.
    always_comb begin
        busy_next = busy;
        if (reg_write) begin
            busy_next[rd] = 1'b0;
        end
        if (alloc_fire) begin
            busy_next[alloc_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy   <= '0;
            wb_err <= 1'b0;
        end else begin
            busy <= busy_next;
            if (err_push) begin
                wb_err <= 1'b1;
            end
        end
    end

    // Storage carries no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (exu_push) begin
            rd_mem[tail]   <= exu_rd;
            data_mem[tail] <= exu_data;
        end
        if (lsu_push) begin
            rd_mem[lsu_slot]   <= lsu_rd;
            data_mem[lsu_slot] <= lsu_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            rd        <= '0;
            result    <= '0;
            reg_write <= 1'b0;
        end else begin
            tail  <= tail + PTR_W'(exu_push) + PTR_W'(lsu_push);
            count <= count + (PTR_W+1)'(exu_push) + (PTR_W+1)'(lsu_push)
                     - (PTR_W+1)'(pop);
            if (pop) begin
                rd        <= rd_mem[head];
                result    <= data_mem[head];
                reg_write <= 1'b1;
                head      <= head + 1'b1;
            end else begin
                reg_write <= 1'b0;
            end
        end
    end

endmodule
